// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the 640x480@60 VGA raster generator.
//   - Default horizontal/vertical timing values (pixels / lines).
//   - h_total()/v_total(): derive the full line/frame length from the four timing parts.
//   - CoordW: width of the pixel_x/pixel_y raster coordinates.
//   - sync_bits_t: the three timing outputs that travel through the alignment delay line.
package vga_pkg;

    localparam int unsigned CoordW       = 10;
    localparam int unsigned FrameCountW  = 8;

    localparam int unsigned DefHActive   = 640;
    localparam int unsigned DefHFp       = 16;
    localparam int unsigned DefHSync     = 96;
    localparam int unsigned DefHBp       = 48;
    localparam int unsigned DefVActive   = 480;
    localparam int unsigned DefVFp       = 10;
    localparam int unsigned DefVSync     = 2;
    localparam int unsigned DefVBp       = 33;
    localparam int unsigned DefSyncDelay = 2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_bits_t;

    // Inactive levels: both syncs idle high, blanking.
    localparam sync_bits_t SyncIdle = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster/timing bundle produced by vga_timing and consumed by the renderers.
//   pixel_x, pixel_y : undelayed raster coordinates
//   pixel_ce         : counter-advance enable
//   hsync, vsync     : active-low syncs, delayed to match the render latency
//   video_on         : active-area flag, delayed to match the render latency
//   frame_end        : one-tick pulse on the last pixel of a frame
//   frame_count      : frames completed since reset (wraps)
// Modports: master (the timing generator drives), slave (renderers observe).
interface vga_timing_if;
    import vga_pkg::*;

    logic [CoordW-1:0]      pixel_x;
    logic [CoordW-1:0]      pixel_y;
    logic                   pixel_ce;
    logic                   hsync;
    logic                   vsync;
    logic                   video_on;
    logic                   frame_end;
    logic [FrameCountW-1:0] frame_count;

    modport master (
        output pixel_x, pixel_y, pixel_ce, hsync, vsync, video_on, frame_end, frame_count
    );

    modport slave (
        input pixel_x, pixel_y, pixel_ce, hsync, vsync, video_on, frame_end, frame_count
    );

endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: Depth-stage shift register with clock enable, used to keep the sync and
// blanking terms aligned with registered renderer outputs.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset; every stage loads ResetVal
//   en_i   : shift enable
//   d_i    : input word (Width bits)
//   q_o    : input delayed by Depth enabled ticks; Depth = 0 is a combinational bypass
module sync_delay_line #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (Depth == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_ni, en_i};
        assign q_o = d_i;
    end else begin : g_pipe
        logic [Width-1:0] stage_q [Depth];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    stage_q[i] <= ResetVal;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int unsigned i = 1; i < Depth; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[Depth-1];
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster generator (640x480@60 by default).
//   clk_0 : pixel/system clock
//   rst   : asynchronous active-low reset
//   vga   : vga_timing_if.master -- pixel_x/pixel_y (undelayed), pixel_ce, hsync/vsync/video_on
//           (delayed by SYNC_DELAY ticks), frame_end pulse, frame_count
// Optional build macro VGA_PIXEL_DIV2_EN: pixel_ce toggles every clk_0 cycle so a 50 MHz clock
// yields a 25 MHz pixel rate; all state advances only on pixel_ce ticks. Without the macro
// pixel_ce is tied high.
// With SYNC_DELAY = 0 the sync/blanking outputs are the raw combinational terms of the counters.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DefHActive,
    parameter int unsigned H_FP       = DefHFp,
    parameter int unsigned H_SYNC     = DefHSync,
    parameter int unsigned H_BP       = DefHBp,
    parameter int unsigned V_ACTIVE   = DefVActive,
    parameter int unsigned V_FP       = DefVFp,
    parameter int unsigned V_SYNC     = DefVSync,
    parameter int unsigned V_BP       = DefVBp,
    parameter int unsigned SYNC_DELAY = DefSyncDelay
) (
    input  logic         clk_0,
    input  logic         rst,
    vga_timing_if.master vga
);

    localparam int unsigned HTotal = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTotal = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CoordW-1:0] HLast      = CoordW'(HTotal - 1);
    localparam logic [CoordW-1:0] VLast      = CoordW'(VTotal - 1);
    localparam logic [CoordW-1:0] HActEnd    = CoordW'(H_ACTIVE);
    localparam logic [CoordW-1:0] VActEnd    = CoordW'(V_ACTIVE);
    localparam logic [CoordW-1:0] HSyncStart = CoordW'(H_ACTIVE + H_FP);
    localparam logic [CoordW-1:0] HSyncEnd   = CoordW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CoordW-1:0] VSyncStart = CoordW'(V_ACTIVE + V_FP);
    localparam logic [CoordW-1:0] VSyncEnd   = CoordW'(V_ACTIVE + V_FP + V_SYNC);

    logic                   pixel_ce;
    logic                   ce_next;  // value pixel_ce takes in the following cycle
    logic [CoordW-1:0]      x_q, x_d;
    logic [CoordW-1:0]      y_q, y_d;
    logic                   started_q, started_d;
    logic                   frame_end_q, frame_end_d;
    logic [FrameCountW-1:0] frame_count_q, frame_count_d;
    sync_bits_t             raw;
    sync_bits_t             dly;

`ifdef VGA_PIXEL_DIV2_EN
    logic ce_q;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            ce_q <= 1'b0;
        end else begin
            ce_q <= ~ce_q;
        end
    end

    assign pixel_ce = ce_q;
    assign ce_next  = ~ce_q;
`else
    assign pixel_ce = 1'b1;
    assign ce_next  = 1'b1;
`endif

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        started_d     = started_q;
        frame_count_d = frame_count_q;

        if (pixel_ce) begin
            // The first tick after reset only arms the counters; they hold at (0,0).
            started_d = 1'b1;
            if (started_q) begin
                if (x_q == HLast) begin
                    x_d = '0;
                    y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            // frame_end is high exactly on the tick the counters wrap to (0,0).
            if (frame_end_q) begin
                frame_count_d = frame_count_q + 1'b1;
            end
        end

        // Registered pulse that is high while the counters show the last pixel; with the
        // divided clock it is restricted to the pixel_ce=1 cycle of that pixel.
        frame_end_d = ce_next && (x_d == HLast) && (y_d == VLast);
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            x_q           <= '0;
            y_q           <= '0;
            started_q     <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            started_q     <= started_d;
            frame_end_q   <= frame_end_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        raw          = SyncIdle;
        raw.hsync    = !((x_q >= HSyncStart) && (x_q < HSyncEnd));
        raw.vsync    = !((y_q >= VSyncStart) && (y_q < VSyncEnd));
        raw.video_on = (x_q < HActEnd) && (y_q < VActEnd);
    end

    sync_delay_line #(
        .Width    (3),
        .Depth    (SYNC_DELAY),
        .ResetVal (SyncIdle)
    ) u_sync_delay (
        .clk_i  (clk_0),
        .rst_ni (rst),
        .en_i   (pixel_ce),
        .d_i    (raw),
        .q_o    (dly)
    );

    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.pixel_ce    = pixel_ce;
    assign vga.hsync       = dly.hsync;
    assign vga.vsync       = dly.vsync;
    assign vga.video_on    = dly.video_on;
    assign vga.frame_end   = frame_end_q;
    assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: three vga_timing instances sharing clock and reset -- default timing with
// SYNC_DELAY=2, default timing with SYNC_DELAY=0, and a reduced 11x7 raster for frame wrap.
// Every cycle each instance is compared with a model that derives all outputs from the number
// of clock edges since reset release; a few measured intervals are checked against literals.
module tb_vga_timing;

`ifdef VGA_PIXEL_DIV2_EN
    localparam int Div = 2;
`else
    localparam int Div = 1;
`endif
    localparam int MeasEnd = 2000 * Div;

    typedef struct packed {
        int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb; int d;
    } cfg_t;

    typedef struct {
        int x; int y; int ce; int hs; int vs; int vo; int fe; int fc;
    } exp_t;

    localparam cfg_t Cfg0 = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam cfg_t Cfg1 = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    localparam cfg_t Cfg2 = '{8, 1, 1, 1, 4, 1, 1, 1, 2};

    logic clk;
    logic rst;
    int   k;  // clock edges since reset release
    int   n_pass;
    int   n_total;
    bit   chk_en, meas_en, wrap_en, final_req;

    vga_timing_if vif0 ();
    vga_timing_if vif1 ();
    vga_timing_if vif2 ();

    vga_timing #(.SYNC_DELAY(2)) u_dut0 (.clk_0(clk), .rst(rst), .vga(vif0));
    vga_timing #(.SYNC_DELAY(0)) u_dut1 (.clk_0(clk), .rst(rst), .vga(vif1));
    vga_timing #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(2)
    ) u_dut2 (.clk_0(clk), .rst(rst), .vga(vif2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    // Raster position after t ticks: the first tick holds at 0, then one pixel per tick.
    function automatic exp_t model(input cfg_t c, input int kk);
        exp_t e;
        int ht, vt, tot, t, pos, s, ps, px, py, ce_now;
`ifdef VGA_PIXEL_DIV2_EN
        t = kk / 2;
        ce_now = kk % 2;
`else
        t = kk;
        ce_now = 1;
`endif
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        tot = ht * vt;
        pos = (t > 0) ? t - 1 : 0;
        e.x  = pos % ht;
        e.y  = (pos / ht) % vt;
        e.ce = ce_now;
        e.fe = (t >= 1 && ce_now == 1 && (pos % tot) == tot - 1) ? 1 : 0;
        e.fc = (pos / tot) % 256;
        if (t >= c.d) begin
            s  = t - c.d;
            ps = (s > 0) ? s - 1 : 0;
            px = ps % ht;
            py = (ps / ht) % vt;
            e.hs = (px >= c.ha + c.hf && px < c.ha + c.hf + c.hs) ? 0 : 1;
            e.vs = (py >= c.va + c.vf && py < c.va + c.vf + c.vs) ? 0 : 1;
            e.vo = (px < c.ha && py < c.va) ? 1 : 0;
        end else begin
            e.hs = 1;
            e.vs = 1;
            e.vo = 0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (k=%0d, t=%0t)", name, act, exp, k, $time);
    endtask

    task automatic check_dut(input string tag, input cfg_t c, input int px, input int py,
                             input int ce, input int hs, input int vs, input int vo,
                             input int fe, input int fc);
        exp_t e;
        e = model(c, k);
        chk({tag, ".pixel_x"}, px, e.x);
        chk({tag, ".pixel_y"}, py, e.y);
        chk({tag, ".pixel_ce"}, ce, e.ce);
        chk({tag, ".hsync"}, hs, e.hs);
        chk({tag, ".vsync"}, vs, e.vs);
        chk({tag, ".video_on"}, vo, e.vo);
        chk({tag, ".frame_end"}, fe, e.fe);
        chk({tag, ".frame_count"}, fc, e.fc);
    endtask

    // Interval trackers, cleared whenever the design is held in reset.
    int x656_0, fall0a, fall0b, hs0_low, vo0_hi;
    int x656_1, fall1, x640_1, vofall1;
    int fe2a, fe2b, vs2_low, fe2_hi;
    int prev_fc2;
    bit prev_hs0, prev_hs1, prev_vo1, prev_fe2, saw_wrap;

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut("d0", Cfg0, int'(vif0.pixel_x), int'(vif0.pixel_y), int'(vif0.pixel_ce),
                      int'(vif0.hsync), int'(vif0.vsync), int'(vif0.video_on),
                      int'(vif0.frame_end), int'(vif0.frame_count));
            check_dut("d1", Cfg1, int'(vif1.pixel_x), int'(vif1.pixel_y), int'(vif1.pixel_ce),
                      int'(vif1.hsync), int'(vif1.vsync), int'(vif1.video_on),
                      int'(vif1.frame_end), int'(vif1.frame_count));
            check_dut("d2", Cfg2, int'(vif2.pixel_x), int'(vif2.pixel_y), int'(vif2.pixel_ce),
                      int'(vif2.hsync), int'(vif2.vsync), int'(vif2.video_on),
                      int'(vif2.frame_end), int'(vif2.frame_count));
        end

        if (k == 0) begin
            x656_0 = -1; fall0a = -1; fall0b = -1; hs0_low = 0; vo0_hi = 0;
            x656_1 = -1; fall1 = -1; x640_1 = -1; vofall1 = -1;
            fe2a = -1; fe2b = -1; vs2_low = 0; fe2_hi = 0;
            prev_fc2 = 0; saw_wrap = 1'b0;
        end else begin
            if (x656_0 < 0 && vif0.pixel_x == 10'd656) x656_0 = k;
            if (prev_hs0 && !vif0.hsync) begin
                if (fall0a < 0) fall0a = k;
                else if (fall0b < 0) fall0b = k;
            end
            if (k >= 1000 * Div && k < 1800 * Div) begin
                if (!vif0.hsync) hs0_low++;
                if (vif0.video_on) vo0_hi++;
            end
            if (x656_1 < 0 && vif1.pixel_x == 10'd656) x656_1 = k;
            if (x640_1 < 0 && vif1.pixel_x == 10'd640) x640_1 = k;
            if (fall1 < 0 && prev_hs1 && !vif1.hsync) fall1 = k;
            if (vofall1 < 0 && prev_vo1 && !vif1.video_on) vofall1 = k;
            if (!prev_fe2 && vif2.frame_end) begin
                if (fe2a < 0) fe2a = k;
                else if (fe2b < 0) fe2b = k;
            end
            if (k >= 200 * Div && k < 277 * Div) begin
                if (!vif2.vsync) vs2_low++;
                if (vif2.frame_end) fe2_hi++;
            end
            if (wrap_en && int'(vif2.frame_count) != prev_fc2) begin
                chk("fc2_step", int'(vif2.frame_count), (prev_fc2 + 1) % 256);
                if (prev_fc2 == 255) saw_wrap = 1'b1;
            end
            prev_fc2 = int'(vif2.frame_count);
        end

        if (meas_en && k == MeasEnd) begin
            chk("h0_fall_after_x656", fall0a - x656_0, 2 * Div);
            chk("h0_line_period", fall0b - fall0a, 800 * Div);
            chk("h0_low_per_line", hs0_low, 96 * Div);
            chk("vo0_high_per_line", vo0_hi, 640 * Div);
            chk("h1_fall_after_x656", fall1 - x656_1, 0);
            chk("vo1_fall_after_x640", vofall1 - x640_1, 0);
            chk("fe2_frame_period", fe2b - fe2a, 77 * Div);
            chk("vs2_low_per_frame", vs2_low, 11 * Div);
            chk("fe2_high_per_frame", fe2_hi, 1);
        end

        if (final_req) chk("fc2_wrap_255_to_0", int'(saw_wrap), 1);

        prev_hs0 = vif0.hsync;
        prev_hs1 = vif1.hsync;
        prev_vo1 = vif1.video_on;
        prev_fe2 = vif2.frame_end;
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        chk_en = 1'b0;
        meas_en = 1'b0;
        wrap_en = 1'b0;
        final_req = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Directed line/frame timing measurements from a clean release.
        #1 meas_en = 1'b1;
        rst = 1'b1;
        repeat (MeasEnd + 4) @(negedge clk);
        #1 meas_en = 1'b0;

        // Random run lengths with reset asserted asynchronously between clock edges.
        repeat (6) begin
            repeat ($urandom_range(50, 1500) * Div) @(negedge clk);
            @(posedge clk);
            #($urandom_range(1, 4)) rst = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1 rst = 1'b1;
        end

        // Long run: more than 256 reduced frames so frame_count wraps.
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        wrap_en = 1'b1;
        repeat (20000 * Div) @(negedge clk);
        #1 wrap_en = 1'b0;
        final_req = 1'b1;
        @(negedge clk);
        #1 final_req = 1'b0;
        #1 $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
